// File: rtl/instr_cycle_ctrl_if.sv
// Control/strobe bundle between the instruction sequencer and the datapath around it.
// i_step_mode/i_step exist only when SINGLE_STEP_EN is defined.
interface instr_cycle_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
`ifdef SINGLE_STEP_EN
    logic             i_step_mode;
    logic             i_step;
`endif
    logic             i_run;
    logic             i_mem_ready;
    logic             i_op_writes_w;
    logic             i_op_is_branch;
    logic             o_mem_rd;
    logic             o_load_ir;
    logic             o_pc_inc;
    logic             o_load_pc;
    logic             o_load_w;
    logic [1:0]       o_phase;
    logic             o_busy;
    logic             o_fault;
    logic [CNT_W-1:0] o_instr_cnt;

    modport master (
`ifdef SINGLE_STEP_EN
        output i_step_mode,
        output i_step,
`endif
        output i_run,
        output i_mem_ready,
        output i_op_writes_w,
        output i_op_is_branch,
        input  o_mem_rd,
        input  o_load_ir,
        input  o_pc_inc,
        input  o_load_pc,
        input  o_load_w,
        input  o_phase,
        input  o_busy,
        input  o_fault,
        input  o_instr_cnt
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        input  i_step_mode,
        input  i_step,
`endif
        input  i_run,
        input  i_mem_ready,
        input  i_op_writes_w,
        input  i_op_is_branch,
        output o_mem_rd,
        output o_load_ir,
        output o_pc_inc,
        output o_load_pc,
        output o_load_w,
        output o_phase,
        output o_busy,
        output o_fault,
        output o_instr_cnt
    );
endinterface

// File: rtl/instr_cycle_ctrl.sv
// Instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK strobes, fetch timeout, retire count.
// Defining SINGLE_STEP_EN adds a HOLD state between instructions, released by a step pulse.
module instr_cycle_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input logic               i_clk,
    input logic               i_rst_n,
    instr_cycle_ctrl_if.slave bus
);

    localparam int unsigned       WAIT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

`ifdef SINGLE_STEP_EN
    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StWriteback, StFault, StHold
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StWriteback, StFault
    } state_e;
`endif

    state_e            r_state, w_state_d;
    logic [WAIT_W-1:0] r_wait, w_wait_d;
    logic [CNT_W-1:0]  r_instr_cnt, w_cnt_d;
    logic              r_op_w, r_op_br;
    logic              w_mem_rd, w_load_ir, w_pc_inc, w_load_pc, w_load_w;
    logic [1:0]        w_phase;
    logic              w_busy, w_fault;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_wait      <= '0;
            r_instr_cnt <= '0;
            r_op_w      <= 1'b0;
            r_op_br     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_wait      <= w_wait_d;
            r_instr_cnt <= w_cnt_d;
            if (r_state == StDecode) begin
                r_op_w  <= bus.i_op_writes_w;
                r_op_br <= bus.i_op_is_branch;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_wait_d  = '0;
        w_cnt_d   = r_instr_cnt;
        w_mem_rd  = 1'b0;
        w_load_ir = 1'b0;
        w_pc_inc  = 1'b0;
        w_load_pc = 1'b0;
        w_load_w  = 1'b0;
        w_phase   = 2'd0;
        w_busy    = 1'b0;
        w_fault   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.i_run) w_state_d = StFetch;
            end
            StFetch: begin
                w_busy   = 1'b1;
                w_mem_rd = 1'b1;
                // Data arriving on the last allowed cycle still beats the timeout.
                if (bus.i_mem_ready) begin
                    w_load_ir = 1'b1;
                    w_state_d = StDecode;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_d = StFault;
                end else begin
                    w_wait_d = r_wait + WAIT_W'(1);
                end
            end
            StDecode: begin
                w_busy    = 1'b1;
                w_phase   = 2'd1;
                w_state_d = StExecute;
            end
            StExecute: begin
                w_busy    = 1'b1;
                w_phase   = 2'd2;
                w_load_pc = r_op_br;
                w_pc_inc  = ~r_op_br;
                w_state_d = StWriteback;
            end
            StWriteback: begin
                w_busy   = 1'b1;
                w_phase  = 2'd3;
                w_load_w = r_op_w;
                w_cnt_d  = r_instr_cnt + CNT_W'(1);
                if (!bus.i_run) begin
                    w_state_d = StIdle;
`ifdef SINGLE_STEP_EN
                end else if (bus.i_step_mode) begin
                    w_state_d = StHold;
`endif
                end else begin
                    w_state_d = StFetch;
                end
            end
            StFault: begin
                w_fault = 1'b1;
                if (!bus.i_run) w_state_d = StIdle;
            end
`ifdef SINGLE_STEP_EN
            StHold: begin
                w_busy = 1'b1;
                if (!bus.i_run) begin
                    w_state_d = StIdle;
                end else if (bus.i_step) begin
                    w_state_d = StFetch;
                end
            end
`endif
            default: w_state_d = StIdle;
        endcase
    end

    assign bus.o_mem_rd    = w_mem_rd;
    assign bus.o_load_ir   = w_load_ir;
    assign bus.o_pc_inc    = w_pc_inc;
    assign bus.o_load_pc   = w_load_pc;
    assign bus.o_load_w    = w_load_w;
    assign bus.o_phase     = w_phase;
    assign bus.o_busy      = w_busy;
    assign bus.o_fault     = w_fault;
    assign bus.o_instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Bench for instr_cycle_ctrl: directed sequences plus a randomized instruction stream
// scored against per-instruction expectations (fetch length, strobes, retire count).
module tb_instr_cycle_ctrl;

    localparam int unsigned CntW       = 4;
    localparam int unsigned TimeoutCyc = 8;

    // {mem_rd, load_ir, pc_inc, load_pc, load_w, phase[1:0], busy, fault}
    localparam logic [8:0] OutIdle    = 9'b0_0000_00_0_0;
    localparam logic [8:0] OutFetch   = 9'b1_0000_00_1_0;
    localparam logic [8:0] OutFetchLd = 9'b1_1000_00_1_0;
    localparam logic [8:0] OutDec     = 9'b0_0000_01_1_0;
    localparam logic [8:0] OutExeInc  = 9'b0_0100_10_1_0;
    localparam logic [8:0] OutExePc   = 9'b0_0010_10_1_0;
    localparam logic [8:0] OutWbW     = 9'b0_0001_11_1_0;
    localparam logic [8:0] OutWb      = 9'b0_0000_11_1_0;
    localparam logic [8:0] OutFault   = 9'b0_0000_00_0_1;

    typedef struct {
        int waits;
        bit wr;
        bit br;
    } instr_t;

    typedef struct {
        int fetch_cyc;
        bit wr;
        bit br;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic man_ready = 1'b0;
    logic man_wr = 1'b0;
    logic man_br = 1'b0;
    logic use_resp = 1'b0;
    logic resp_ready = 1'b0;
    logic resp_wr = 1'b0;
    logic resp_br = 1'b0;
    bit   sb_en = 1'b0;

    int total = 0;
    int bad = 0;

    instr_t plan_q[$];
    exp_t   exp_q[$];

    instr_cycle_ctrl_if #(.CNT_W(CntW)) bus ();

    instr_cycle_ctrl #(
        .CNT_W      (CntW),
        .TIMEOUT_CYC(TimeoutCyc)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    assign bus.i_run          = run;
    assign bus.i_mem_ready    = use_resp ? resp_ready : man_ready;
    assign bus.i_op_writes_w  = use_resp ? resp_wr : man_wr;
    assign bus.i_op_is_branch = use_resp ? resp_br : man_br;

`ifdef SINGLE_STEP_EN
    logic step_mode = 1'b0;
    logic step = 1'b0;
    assign bus.i_step_mode = step_mode;
    assign bus.i_step      = step;
`endif

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] out_vec();
        return {bus.o_mem_rd, bus.o_load_ir, bus.o_pc_inc, bus.o_load_pc, bus.o_load_w,
                bus.o_phase, bus.o_busy, bus.o_fault};
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [8:0] exp);
        #2;
        check(name, 32'(out_vec()), 32'(exp));
    endtask

    // Program memory model: serves the planned wait states and presents the planned
    // opcode bits only during the cycle right after the fetch completes.
    initial begin
        instr_t cur;
        bit in_fetch;
        int rem;
        cur = '{waits: 0, wr: 1'b0, br: 1'b0};
        in_fetch = 1'b0;
        rem = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!use_resp) begin
                in_fetch = 1'b0;
            end else if (bus.o_mem_rd) begin
                if (!in_fetch) begin
                    in_fetch = 1'b1;
                    if (plan_q.size() > 0) cur = plan_q.pop_front();
                    else cur = '{waits: 0, wr: 1'b0, br: 1'b0};
                    rem = cur.waits;
                end
                resp_ready = (rem == 0);
                if (rem > 0) rem--;
                resp_wr = 1'($urandom);
                resp_br = 1'($urandom);
            end else begin
                if (in_fetch) begin
                    resp_wr = cur.wr;
                    resp_br = cur.br;
                end else begin
                    resp_wr = 1'($urandom);
                    resp_br = 1'($urandom);
                end
                in_fetch = 1'b0;
                resp_ready = 1'($urandom);
            end
        end
    end

    // Monitor: accumulates strobes per instruction and scores each retirement.
    initial begin
        int n_rd, n_inc, n_pc, n_w, since, nstb, cnt_exp;
        bit wb_pend, wb_run;
        exp_t e;
        n_rd = 0; n_inc = 0; n_pc = 0; n_w = 0; since = 0; cnt_exp = 0;
        wb_pend = 1'b0; wb_run = 1'b0;
        forever begin
            @(negedge clk);
            if (!sb_en) begin
                n_rd = 0; n_inc = 0; n_pc = 0; n_w = 0; since = 0;
                wb_pend = 1'b0;
            end else begin
                nstb = int'(bus.o_load_ir) + int'(bus.o_pc_inc) + int'(bus.o_load_pc)
                     + int'(bus.o_load_w);
                check("strobe_exclusive", 32'(nstb <= 1), 32'(1));
                if (wb_pend) begin
                    check("after_wb_fetch", 32'(bus.o_mem_rd), 32'(wb_run));
                    check("instr_cnt", 32'(bus.o_instr_cnt), 32'(cnt_exp));
                    wb_pend = 1'b0;
                end
                n_rd  += int'(bus.o_mem_rd);
                n_inc += int'(bus.o_pc_inc);
                n_pc  += int'(bus.o_load_pc);
                n_w   += int'(bus.o_load_w);
                if (bus.o_load_ir) since = 0;
                else since++;
                if (bus.o_phase == 2'd3) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_retire: got=1 expected=0 at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("fetch_cycles", 32'(n_rd), 32'(e.fetch_cyc));
                        check("pc_inc_count", 32'(n_inc), 32'(!e.br));
                        check("load_pc_count", 32'(n_pc), 32'(e.br));
                        check("load_w_count", 32'(n_w), 32'(e.wr));
                        check("ir_to_wb_cycles", 32'(since), 32'(3));
                        cnt_exp = e.cnt;
                    end
                    wb_run = bus.i_run;
                    wb_pend = 1'b1;
                    n_rd = 0; n_inc = 0; n_pc = 0; n_w = 0;
                end
            end
        end
    end

    initial begin
        instr_t it;
        int cnt_m;

        // Reset held with run=1: everything quiet.
        run = 1'b1; man_ready = 1'b1; man_wr = 1'b1; man_br = 1'b0;
        #12;
        check("reset_outputs", 32'(out_vec()), 32'(OutIdle));
        check("reset_cnt", 32'(bus.o_instr_cnt), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        adv(); expect_out("t1_fetch", OutFetchLd);
        adv(); expect_out("t1_decode", OutDec);
        adv(); expect_out("t1_execute", OutExeInc);
        adv(); run = 1'b0; expect_out("t1_writeback", OutWbW);
        adv(); expect_out("t1_idle", OutIdle);
        check("t1_cnt", 32'(bus.o_instr_cnt), 32'(1));

        // Fetch timeout: 8 stalled fetch cycles, then sticky fault until run drops.
        adv(); run = 1'b1; man_ready = 1'b0; expect_out("t4_idle", OutIdle);
        for (int k = 0; k < int'(TimeoutCyc); k++) begin
            adv(); expect_out("t4_fetch_wait", OutFetch);
        end
        for (int k = 0; k < 3; k++) begin
            adv(); expect_out("t4_fault_sticky", OutFault);
        end
        adv(); run = 1'b0; expect_out("t4_fault_last", OutFault);
        adv(); expect_out("t4_fault_clear", OutIdle);

        // Run dropped in DECODE: branch instruction still completes.
        adv(); run = 1'b1; man_ready = 1'b1; man_wr = 1'b0; man_br = 1'b1;
        expect_out("t5_idle", OutIdle);
        adv(); expect_out("t5_fetch", OutFetchLd);
        adv(); run = 1'b0; expect_out("t5_decode", OutDec);
        adv(); expect_out("t5_execute_branch", OutExePc);
        adv(); expect_out("t5_writeback", OutWb);
        adv(); expect_out("t5_idle_after", OutIdle);
        check("t5_cnt", 32'(bus.o_instr_cnt), 32'(2));

        // Reset asserted mid-EXECUTE: immediate idle, writeback never happens.
        adv(); run = 1'b1; man_wr = 1'b1; man_br = 1'b0; expect_out("t5b_idle", OutIdle);
        adv(); expect_out("t5b_fetch", OutFetchLd);
        adv(); expect_out("t5b_decode", OutDec);
        adv(); expect_out("t5b_execute", OutExeInc);
        #1; rst_n = 1'b0;
        #1; check("t5b_async_reset", 32'(out_vec()), 32'(OutIdle));
        check("t5b_reset_cnt", 32'(bus.o_instr_cnt), 32'(0));
        adv(); expect_out("t5b_no_load_w", OutIdle);
        run = 1'b0;
        rst_n = 1'b1;

`ifdef SINGLE_STEP_EN
        // Single-step: each step pulse retires exactly one instruction.
        step_mode = 1'b1;
        adv(); run = 1'b1; man_wr = 1'b1; man_br = 1'b0; expect_out("ss_idle", OutIdle);
        for (int r = 1; r <= 3; r++) begin
            adv(); step = 1'b0; expect_out("ss_fetch", OutFetchLd);
            adv(); expect_out("ss_decode", OutDec);
            adv(); expect_out("ss_execute", OutExeInc);
            adv(); expect_out("ss_writeback", OutWbW);
            adv(); expect_out("ss_hold", OutFetch & 9'b0_0000_00_1_0);
            adv(); expect_out("ss_hold_wait", 9'b0_0000_00_1_0);
            check("ss_cnt", 32'(bus.o_instr_cnt), 32'(r));
            adv();
            if (r == 3) run = 1'b0;
            step = 1'b1;
            expect_out("ss_hold_step", 9'b0_0000_00_1_0);
        end
        adv(); step = 1'b0; expect_out("ss_run_low_wins", OutIdle);
        check("ss_cnt_final", 32'(bus.o_instr_cnt), 32'(3));
        step_mode = 1'b0;
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
`endif

        // Randomized stream: covers every wait count up to the timeout boundary,
        // random run gaps, branches/writes, and the counter wrap.
        cnt_m = 0;
        for (int i = 0; i < 40; i++) begin
            it.waits = (i < int'(TimeoutCyc)) ? i : int'($urandom_range(0, TimeoutCyc - 1));
            it.wr = 1'($urandom);
            it.br = (i == 1) ? 1'b1 : 1'($urandom);
            plan_q.push_back(it);
            cnt_m = (cnt_m + 1) % (1 << CntW);
            exp_q.push_back('{fetch_cyc: it.waits + 1, wr: it.wr, br: it.br, cnt: cnt_m});
        end
        use_resp = 1'b1;
        sb_en = 1'b1;
        for (int cyc = 0; cyc < 3000 && exp_q.size() > 0; cyc++) begin
            adv();
            run = (plan_q.size() > 0) && ($urandom_range(0, 7) != 0);
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        run = 1'b0;
        repeat (3) adv();
        check("final_idle", 32'(out_vec()), 32'(OutIdle));
        sb_en = 1'b0;
        use_resp = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
